// File: rtl/audio_clkgen_pkg.sv
// Shared types and constant helpers for the NCO-based audio clock generator.
package audio_clkgen_pkg;

   localparam int ACC_W_DEFAULT = 32;

   typedef logic [ACC_W_DEFAULT-1:0] incr_t;

   // Width of a channel selector; a single channel still gets one bit.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Clamp an increment to half the accumulator range (f_refclk/2 ceiling).
   function automatic logic [63:0] saturate(input logic [63:0] v, input int unsigned acc_w);
      logic [63:0] half;
      half = 64'd1 << (acc_w - 1);
      return (v > half) ? half : v;
   endfunction

   // incr = f_out * 2^acc_w / f_ref, truncated.
   function automatic logic [63:0] freq_to_incr(input logic [63:0] f_out,
                                                input logic [63:0] f_ref,
                                                input int unsigned acc_w);
      return (f_out << acc_w) / f_ref;
   endfunction

   localparam incr_t INIT_INCR_DEFAULT =
      incr_t'(freq_to_incr(64'd18432000, 64'd50000000, ACC_W_DEFAULT));

endpackage

// File: rtl/audio_clkgen_nco_if.sv
// Increment-update request port: valid/ready handshake with channel select.
interface audio_clkgen_nco_if
   import audio_clkgen_pkg::*;
#(
   parameter int NUM_CLKS = 3,
   parameter int ACC_W    = 32
);
   localparam int SEL_W = sel_width(NUM_CLKS);

   logic             cfg_valid;
   logic             cfg_ready;
   logic [SEL_W-1:0] cfg_sel;
   logic [ACC_W-1:0] cfg_incr;

   modport master (output cfg_valid, output cfg_sel, output cfg_incr, input cfg_ready);
   modport slave  (input cfg_valid, input cfg_sel, input cfg_incr, output cfg_ready);

endinterface

// File: rtl/audio_clkgen_nco_chan.sv
// One NCO channel: phase accumulator, pending increment and glitch-free commit
// at the accumulator wrap, plus the MSB clock output and its rising-edge tick.
module audio_clkgen_nco_chan
   import audio_clkgen_pkg::*;
#(
   parameter int          ACC_W     = 32,
   parameter logic [63:0] INIT_INCR = 64'(INIT_INCR_DEFAULT)
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             enable,
   input  logic             load,
   input  logic [ACC_W-1:0] load_incr,
   output logic             pending,
   output logic             outclk,
   output logic             tick
);
   localparam logic [ACC_W-1:0] RESET_INCR = ACC_W'(saturate(INIT_INCR, ACC_W));

   logic [ACC_W-1:0] acc_reg, acc_next;
   logic [ACC_W-1:0] incr_active_reg, incr_active_next;
   logic [ACC_W-1:0] incr_pending_reg, incr_pending_next;
   logic             pending_reg, pending_next;
   logic             tick_reg, tick_next;
   logic [ACC_W:0]   sum;
   logic             carry;
   logic             stopped;
   logic             commit;

   always_comb begin
      sum               = {1'b0, acc_reg} + {1'b0, incr_active_reg};
      carry             = sum[ACC_W];
      stopped           = (incr_active_reg == '0);
      // A stopped channel never wraps, so it commits on the next enabled cycle.
      commit            = enable && pending_reg && (carry || stopped);
      acc_next          = acc_reg;
      incr_active_next  = incr_active_reg;
      incr_pending_next = incr_pending_reg;
      pending_next      = pending_reg;
      tick_next         = 1'b0;

      if (enable) begin
         acc_next  = (commit && stopped) ? '0 : sum[ACC_W-1:0];
         tick_next = acc_next[ACC_W-1] & ~acc_reg[ACC_W-1];
      end
      if (commit) begin
         incr_active_next = incr_pending_reg;
         pending_next     = 1'b0;
      end
      if (load) begin
         incr_pending_next = load_incr;
         pending_next      = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         acc_reg          <= '0;
         incr_active_reg  <= RESET_INCR;
         incr_pending_reg <= '0;
         pending_reg      <= 1'b0;
         tick_reg         <= 1'b0;
      end else begin
         acc_reg          <= acc_next;
         incr_active_reg  <= incr_active_next;
         incr_pending_reg <= incr_pending_next;
         pending_reg      <= pending_next;
         tick_reg         <= tick_next;
      end
   end

   assign pending = pending_reg;
   assign outclk  = acc_reg[ACC_W-1];
   assign tick    = tick_reg;

endmodule

// File: rtl/audio_clkgen_nco.sv
// Multi-output audio clock generator: NUM_CLKS runtime-programmable NCOs with
// a shared config port and a lock indicator.
module audio_clkgen_nco
   import audio_clkgen_pkg::*;
#(
   parameter int          NUM_CLKS    = 3,
   parameter int          ACC_W       = 32,
   parameter logic [63:0] INIT_INCR   = 64'(INIT_INCR_DEFAULT),
   parameter int          LOCK_CYCLES = 16
) (
   input  logic                refclk,
   input  logic                rst,
   input  logic                enable,
   audio_clkgen_nco_if.slave   cfg,
   output logic [NUM_CLKS-1:0] outclk,
   output logic [NUM_CLKS-1:0] tick,
   output logic                locked
);
   localparam int SEL_W = sel_width(NUM_CLKS);
   localparam logic [7:0] LOCK_MAX = 8'(LOCK_CYCLES);

   logic [NUM_CLKS-1:0] pending;
   logic [NUM_CLKS-1:0] load;
   logic [ACC_W-1:0]    cfg_incr_sat;
   logic                ready;
   logic                accept;
   logic [7:0]          lock_cnt_reg, lock_cnt_next;
   logic                locked_reg;

   // Out-of-range selectors are always ready so they are accepted and dropped.
   always_comb begin
      ready = 1'b1;
      for (int i = 0; i < NUM_CLKS; i++) begin
         if (cfg.cfg_sel == SEL_W'(i)) begin
            ready = ~pending[i];
         end
      end
   end

   assign cfg.cfg_ready = ready;
   assign accept        = cfg.cfg_valid & ready;
   assign cfg_incr_sat  = ACC_W'(saturate(64'(cfg.cfg_incr), ACC_W));

   for (genvar gi = 0; gi < NUM_CLKS; gi++) begin : g_chan
      assign load[gi] = accept && (cfg.cfg_sel == SEL_W'(gi));

      audio_clkgen_nco_chan #(
         .ACC_W     (ACC_W),
         .INIT_INCR (INIT_INCR)
      ) u_chan (
         .clk       (refclk),
         .srst      (rst),
         .enable    (enable),
         .load      (load[gi]),
         .load_incr (cfg_incr_sat),
         .pending   (pending[gi]),
         .outclk    (outclk[gi]),
         .tick      (tick[gi])
      );
   end

   always_comb begin
      lock_cnt_next = lock_cnt_reg;
      if (accept || !enable) begin
         lock_cnt_next = '0;
      end else if ((pending == '0) && (lock_cnt_reg != LOCK_MAX)) begin
         lock_cnt_next = lock_cnt_reg + 8'd1;
      end
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         lock_cnt_reg <= '0;
         locked_reg   <= 1'b0;
      end else begin
         lock_cnt_reg <= lock_cnt_next;
         locked_reg   <= (lock_cnt_next == LOCK_MAX);
      end
   end

   assign locked = locked_reg;

endmodule

// File: doc/audio_clkgen_nco.md
Name: audio_clkgen_nco

Overview:
Parametrised multi-output audio clock generator that replaces a fixed-frequency audio PLL with runtime-programmable numerically-controlled oscillators (NCOs).
- Each of NUM_CLKS channels runs a phase accumulator clocked by refclk.
- Each channel produces a ~50%-duty clock-like output and a one-cycle tick strobe.
- Increments are reprogrammable through a valid/ready port; updates take effect glitch-free at the channel's period boundary.
- A locked flag indicates all channels are running their committed configuration.
- Sits in the audio subsystem between the system clock and the codec/I2S logic (MCLK, BCLK, LRCLK enables).

Parameters:
NUM_CLKS, 3, number of independent NCO channels (1..8)
ACC_W, 32, phase accumulator width; f_out = incr * f_refclk / 2^ACC_W
INIT_INCR, 1583296743, reset increment for every channel (18.432 MHz at 50 MHz refclk)
LOCK_CYCLES, 16, consecutive stable cycles required before locked asserts (1..255)

Ports:
refclk  in  1  sole clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
enable  in  1  1 = accumulators advance; 0 = freeze
cfg_valid  in  1  increment update request
cfg_ready  out  1  request may be accepted this cycle
cfg_sel  in  max(1,$clog2(NUM_CLKS))  target channel
cfg_incr  in  ACC_W  new increment
outclk  out  NUM_CLKS  per-channel clock output = accumulator MSB
tick  out  NUM_CLKS  one-cycle strobe, coincident with first cycle of each outclk high phase
locked  out  1  all channels stable for LOCK_CYCLES

Behaviour:
- Reset (rst=1 at edge) sets the following, and discards any pending update:
  - acc = 0; incr_active = INIT_INCR, saturated as below.
  - pending = 0; outclk = 0; tick = 0; locked = 0; lock counter = 0.
- Per channel, each cycle with enable=1: acc <= acc + incr_active (mod 2^ACC_W); carry = overflow of this add.
- outclk[i] is the registered acc[ACC_W-1]. tick[i] is registered and high exactly in the cycle outclk[i] goes 0->1.
- enable=0: acc, outclk and pending are held; tick = 0; locked <= 0; lock counter cleared.
- Saturation: incr > 2^(ACC_W-1) is stored as 2^(ACC_W-1), giving f_refclk/2 with outclk toggling every cycle.
- Configuration:
  - cfg_ready = !pending[cfg_sel], combinational from state.
  - Accept when cfg_valid & cfg_ready: incr_pending[sel] <= saturated cfg_incr; pending[sel] <= 1; locked <= 0; lock counter <= 0.
  - cfg_sel >= NUM_CLKS: request is accepted and dropped, with no state change apart from locked/counter clearing.
- Commit rule (glitch-free): a pending increment is applied on the cycle the channel's add produces carry (acc wraps). That edge loads incr_active <= incr_pending and pending <= 0. The acc sum of that cycle still uses the old increment.
- Stopped channel (incr_active = 0): commit happens on the next enabled cycle, and acc is cleared to 0 on that commit.
- incr_active = 0 means the channel is held at acc const: outclk constant, no tick.
- Simultaneous accept and commit on the same channel is impossible, because cfg_ready=0 while pending.
- Accepts on different channels are independent.
- locked:
  - Counter increments each cycle with enable=1 and no pending bit set; saturates at LOCK_CYCLES.
  - locked = 1 when counter == LOCK_CYCLES; cleared by any accept, by enable=0, or by rst.
  - First lock after reset is asserted on the LOCK_CYCLES-th enabled cycle.
- Latency: cfg accept -> commit between 1 and ceil(2^ACC_W/incr_old) cycles; commit -> locked LOCK_CYCLES cycles.

Decomposition:
- Package audio_clkgen_pkg holds:
  - a typedef for the ACC_W-wide increment;
  - a saturate function;
  - a helper constant for selector width;
  - a freq-to-increment constant function used by INIT_INCR defaults.
- Sub-module audio_clkgen_nco_chan (accumulator, pending register, commit, outclk/tick) is instantiated NUM_CLKS times by generate.
- The top level holds cfg decode, cfg_ready mux and the lock counter.

Test Plan:
- ACC_W=8, INIT_INCR=64, enable=1 after reset -> outclk[0] = 0,0,1,1 repeating, tick on every 4th cycle; locked rises on cycle 16.
- Program ch0 incr=32 while acc=128 -> cfg_ready[ch0] low until wrap; the old 4-cycle period completes, then an 8-cycle period (4 low, 4 high); locked drops and reasserts 16 cycles after commit.
- cfg_incr=200 (ACC_W=8) -> saturated to 128; outclk toggles every cycle, tick every 2nd cycle.
- Channel stopped with incr=0, then program 64 -> commit next cycle, acc=0, then 0,0,1,1 pattern; other channels unaffected.
- enable low for 5 cycles mid-period -> outclk held, tick=0, locked=0; resumes from same phase; locked back 16 cycles after enable rises.
- rst asserted while ch1 update pending -> next cycle pending cleared, incr=INIT_INCR, outclk=0, locked=0, cfg_ready=1.
